hack_ps2_keyboard_decoder: RTL and testbench
============================================

// Module: hack_ps2_keyboard_decoder
// PURPOSE
//   Receives PS/2 keyboard frames, decodes set-2 scan codes to Hack key codes,
//   and drives the Hack keyboard register (key_code -> in, key_load -> load).
//   Sits directly upstream of the memory-mapped keyboard word read by the CPU.
//   Make code of a mapped key writes its Hack code. Release of that key writes 0.
// PARAMETERS
//   FILTER_LEN   4      sys clks ps2_clk must be stable low before an edge is accepted
//   TIMEOUT_CYC  50000  sys clks without a ps2_clk fall mid-frame before the frame is aborted
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   rst_n      in   1   asynchronous, active-low reset
//   ps2_clk    in   1   raw PS/2 clock from the pin (async, idle high)
//   ps2_data   in   1   raw PS/2 data from the pin (async, idle high)
//   key_code   out  16  Hack key code; held between updates
//   key_load   out  1   1-cycle pulse; key_code valid in the same cycle
//   frame_err  out  1   1-cycle pulse on a parity or stop-bit error
// BEHAVIOUR
//   Reset: key_code=0, key_load=0, frame_err=0, FSM=IDLE, e0/f0 flags=0, held=0.
//   Input path: 2-FF synchroniser on both pins.
//     A ps2_clk fall is accepted once sync'd clk has been low for FILTER_LEN
//     consecutive cycles after being high. One accept pulse per fall.
//     Data is sampled on the accept pulse.
//   Frame: start(0), d0..d7 LSB first, odd parity, stop(1).
//   FSM:
//     IDLE: on accept, if data=0 go DATA with bitcnt=0. If data=1, stay IDLE.
//     DATA: shift in 8 bits. After the 8th bit go PARITY.
//     PARITY: latch the parity bit, go STOP.
//     STOP: if stop=1 and parity is odd, byte_valid pulses; otherwise frame_err pulses.
//       Either way go IDLE.
//   Timeout: in DATA/PARITY/STOP, a counter reloads on each accept.
//     At TIMEOUT_CYC -> IDLE, byte discarded, e0/f0 cleared, no frame_err.
//   Frame error: discard the byte and clear e0/f0.
//   Decode, on byte_valid:
//     E0 -> set e0.
//     F0 -> set f0.
//     Otherwise look up {e0,byte}, then clear e0 and f0.
//   Map (unlisted -> unmapped):
//     letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A
//       -> 65..90 ('A'..'Z', shift ignored)
//     45,16,1E,26,25,2E,36,3D,3E,46 -> 48..57; 29 -> 32; 5A -> 128; 66 -> 129
//     E0 6B -> 130 (left), E0 75 -> 131 (up), E0 74 -> 132 (right), E0 72 -> 133 (down)
//     E0 6C -> 134, E0 69 -> 135, E0 7D -> 136, E0 7A -> 137, E0 70 -> 138, E0 71 -> 139
//     76 -> 140; F1..F12 (05,06,04,0C,03,0B,83,0A,01,09,78,07) -> 141..152
//   Make of mapped code c: held<=c, key_code<=c, key_load pulse.
//     Typematic repeats reissue the load pulse with the same c.
//   Break of mapped c with c==held: held<=0, key_code<=0, key_load pulse.
//   Break of c!=held, or any unmapped code: no load, key_code unchanged.
//   Latency: accept pulse that samples the stop bit in cycle N -> byte_valid in N+1
//     -> key_load/key_code in N+2. frame_err also in N+1.
//   key_load and frame_err are never high in the same cycle.
//   Reset mid-frame: everything returns to reset values immediately.
//     The next start bit begins a clean frame.
// TESTING
//   1. Frame 1C, 20 us bit period -> key_load pulses once, key_code=65, frame_err stays 0.
//   2. 1C then F0 1C -> key_code 65 then 0, exactly 2 key_load pulses.
//   3. E0 75 then E0 F0 75 -> key_code 131 then 0. e0 does not leak into the following 1C (gives 65).
//   4. Frame 1C with even parity -> frame_err pulse, no key_load, key_code unchanged.
//      Stop bit=0 -> same result.
//   5. Stop ps2_clk after 4 data bits for more than TIMEOUT_CYC, then send 29
//      -> key_code=32, no frame_err.
//   6. Hold 1C, press 5A, release 1C -> 65, 128, no load on F0 1C.
//      Release 5A -> key_code=0.
//   7. Assert rst_n=0 mid-frame, release, send 45
//      -> outputs 0 during reset, then key_code=48.
//   8. Inject a 2-cycle ps2_clk low glitch with FILTER_LEN=4 -> no bit accepted.

Source files
------------

// File: rtl/hack_ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard receiver feeding the Hack keyboard register.
// Frames are filtered, checked, decoded through the E0/F0 prefixes and mapped to Hack key codes.
module hack_ps2_keyboard_decoder #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_code,
  output logic        key_load,
  output logic        frame_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          armed_q, armed_d, accept_q, accept_d;
  logic [FW-1:0] low_q, low_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
  logic          abort;
  logic          e0_q, e0_d, f0_q, f0_d;
  logic [7:0]    held_q, held_d;
  logic [15:0]   key_code_q, key_code_d;
  logic          key_load_q, key_load_d;
  logic [8:0]    map_res;
  logic          din;

  // Returns {hit, code} for the prefixed scan code {e0, byte}.
  function automatic logic [8:0] lookup(input logic [8:0] sc);
    case (sc)
      9'h01C: lookup = {1'b1, 8'd65};  9'h032: lookup = {1'b1, 8'd66};
      9'h021: lookup = {1'b1, 8'd67};  9'h023: lookup = {1'b1, 8'd68};
      9'h024: lookup = {1'b1, 8'd69};  9'h02B: lookup = {1'b1, 8'd70};
      9'h034: lookup = {1'b1, 8'd71};  9'h033: lookup = {1'b1, 8'd72};
      9'h043: lookup = {1'b1, 8'd73};  9'h03B: lookup = {1'b1, 8'd74};
      9'h042: lookup = {1'b1, 8'd75};  9'h04B: lookup = {1'b1, 8'd76};
      9'h03A: lookup = {1'b1, 8'd77};  9'h031: lookup = {1'b1, 8'd78};
      9'h044: lookup = {1'b1, 8'd79};  9'h04D: lookup = {1'b1, 8'd80};
      9'h015: lookup = {1'b1, 8'd81};  9'h02D: lookup = {1'b1, 8'd82};
      9'h01B: lookup = {1'b1, 8'd83};  9'h02C: lookup = {1'b1, 8'd84};
      9'h03C: lookup = {1'b1, 8'd85};  9'h02A: lookup = {1'b1, 8'd86};
      9'h01D: lookup = {1'b1, 8'd87};  9'h022: lookup = {1'b1, 8'd88};
      9'h035: lookup = {1'b1, 8'd89};  9'h01A: lookup = {1'b1, 8'd90};
      9'h045: lookup = {1'b1, 8'd48};  9'h016: lookup = {1'b1, 8'd49};
      9'h01E: lookup = {1'b1, 8'd50};  9'h026: lookup = {1'b1, 8'd51};
      9'h025: lookup = {1'b1, 8'd52};  9'h02E: lookup = {1'b1, 8'd53};
      9'h036: lookup = {1'b1, 8'd54};  9'h03D: lookup = {1'b1, 8'd55};
      9'h03E: lookup = {1'b1, 8'd56};  9'h046: lookup = {1'b1, 8'd57};
      9'h029: lookup = {1'b1, 8'd32};  9'h05A: lookup = {1'b1, 8'd128};
      9'h066: lookup = {1'b1, 8'd129};
      9'h16B: lookup = {1'b1, 8'd130}; 9'h175: lookup = {1'b1, 8'd131};
      9'h174: lookup = {1'b1, 8'd132}; 9'h172: lookup = {1'b1, 8'd133};
      9'h16C: lookup = {1'b1, 8'd134}; 9'h169: lookup = {1'b1, 8'd135};
      9'h17D: lookup = {1'b1, 8'd136}; 9'h17A: lookup = {1'b1, 8'd137};
      9'h170: lookup = {1'b1, 8'd138}; 9'h171: lookup = {1'b1, 8'd139};
      9'h076: lookup = {1'b1, 8'd140};
      9'h005: lookup = {1'b1, 8'd141}; 9'h006: lookup = {1'b1, 8'd142};
      9'h004: lookup = {1'b1, 8'd143}; 9'h00C: lookup = {1'b1, 8'd144};
      9'h003: lookup = {1'b1, 8'd145}; 9'h00B: lookup = {1'b1, 8'd146};
      9'h083: lookup = {1'b1, 8'd147}; 9'h00A: lookup = {1'b1, 8'd148};
      9'h001: lookup = {1'b1, 8'd149}; 9'h009: lookup = {1'b1, 8'd150};
      9'h078: lookup = {1'b1, 8'd151}; 9'h007: lookup = {1'b1, 8'd152};
      default: lookup = '0;
    endcase
  endfunction

  assign din     = data_sync_q[1];
  assign map_res = lookup({e0_q, shift_q});

  // A fall is accepted only after FILTER_LEN consecutive low samples following a high one.
  always_comb begin
    armed_d  = armed_q;
    low_d    = low_q;
    accept_d = 1'b0;
    if (clk_sync_q[1]) begin
      armed_d = 1'b1;
      low_d   = '0;
    end else if (armed_q) begin
      if (low_q == FW'(FILTER_LEN - 1)) begin
        accept_d = 1'b1;
        armed_d  = 1'b0;
        low_d    = '0;
      end else begin
        low_d = low_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    abort        = 1'b0;
    if (state_q != S_IDLE) begin
      if (accept_q) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        abort   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (accept_q) begin
      case (state_q)
        S_IDLE: if (!din) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
          tmo_d    = '0;
        end
        S_DATA: begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = din;
          state_d  = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (din && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            abort       = 1'b1;
          end
        end
      endcase
    end
  end

  // Break only clears the output when it matches the key currently held.
  always_comb begin
    e0_d       = e0_q;
    f0_d       = f0_q;
    held_d     = held_q;
    key_code_d = key_code_q;
    key_load_d = 1'b0;
    if (abort) begin
      e0_d = 1'b0;
      f0_d = 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == 8'hE0) begin
        e0_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        f0_d = 1'b1;
      end else begin
        e0_d = 1'b0;
        f0_d = 1'b0;
        if (map_res[8]) begin
          if (!f0_q) begin
            held_d     = map_res[7:0];
            key_code_d = {8'h00, map_res[7:0]};
            key_load_d = 1'b1;
          end else if (map_res[7:0] == held_q) begin
            held_d     = '0;
            key_code_d = '0;
            key_load_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      armed_q      <= 1'b0;
      low_q        <= '0;
      accept_q     <= 1'b0;
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      e0_q         <= 1'b0;
      f0_q         <= 1'b0;
      held_q       <= '0;
      key_code_q   <= '0;
      key_load_q   <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      armed_q      <= armed_d;
      low_q        <= low_d;
      accept_q     <= accept_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      e0_q         <= e0_d;
      f0_q         <= f0_d;
      held_q       <= held_d;
      key_code_q   <= key_code_d;
      key_load_q   <= key_load_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_load  = key_load_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hack_ps2_keyboard_decoder.sv
// Directed bench for the PS/2 keyboard decoder: 1 us system clock, 20 us PS/2 bit period.
`timescale 1ns/1ps
module tb_hack_ps2_keyboard_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] key_code;
  logic        key_load;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_load = 0;
  int n_ferr = 0;
  int n_both = 0;
  int load_cyc = 0;
  int ferr_cyc = 0;
  int stop_cyc = 0;
  logic [15:0] last_code = '0;

  hack_ps2_keyboard_decoder #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(500)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_load (key_load),
    .frame_err(frame_err)
  );

  always #500 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_load) begin
      n_load++;
      last_code = key_code;
      load_cyc  = cyc;
    end
    if (frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (key_load && frame_err) n_both++;
  end

  // Sends the first nbits bits of a frame (11 = complete frame).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL reset_key_code got=%0d exp=0", key_code); end
    checks++; if (key_load !== 1'b0) begin errors++; $display("FAIL reset_key_load got=%b exp=0", key_load); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_make;
    int l0, f0;
    l0 = n_load; f0 = n_ferr;
    send(8'h1C);
    checks++; if (n_load - l0 !== 1) begin errors++; $display("FAIL make_loads got=%0d exp=1", n_load - l0); end
    checks++; if (last_code !== 16'd65) begin errors++; $display("FAIL make_load_code got=%0d exp=65", last_code); end
    checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL make_key_code got=%0d exp=65", key_code); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL make_ferr got=%0d exp=0", n_ferr - f0); end
    checks++; if (load_cyc - stop_cyc !== 8) begin errors++; $display("FAIL make_latency got=%0d exp=8", load_cyc - stop_cyc); end
  endtask

  task automatic test_break;
    int l0;
    l0 = n_load;
    send(8'hF0);
    checks++; if (n_load - l0 !== 0) begin errors++; $display("FAIL break_prefix_load got=%0d exp=0", n_load - l0); end
    send(8'h1C);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL break_key_code got=%0d exp=0", key_code); end
    checks++; if (n_load - l0 !== 1) begin errors++; $display("FAIL break_loads got=%0d exp=1", n_load - l0); end
  endtask

  task automatic test_typematic;
    int l0;
    l0 = n_load;
    send(8'h1C); send(8'h1C); send(8'h1C);
    checks++; if (n_load - l0 !== 3) begin errors++; $display("FAIL typematic_loads got=%0d exp=3", n_load - l0); end
    checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL typematic_code got=%0d exp=65", key_code); end
    send(8'hF0); send(8'h1C);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL typematic_release got=%0d exp=0", key_code); end
  endtask

  task automatic test_extended;
    send(8'hE0); send(8'h75);
    checks++; if (key_code !== 16'd131) begin errors++; $display("FAIL ext_up got=%0d exp=131", key_code); end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL ext_up_release got=%0d exp=0", key_code); end
    send(8'h1C);
    checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL ext_no_leak got=%0d exp=65", key_code); end
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h7A);
    checks++; if (key_code !== 16'd137) begin errors++; $display("FAIL ext_7a got=%0d exp=137", key_code); end
    send(8'hE0); send(8'hF0); send(8'h7A);
  endtask

  task automatic test_fkeys_unmapped;
    int l0;
    send(8'h83);
    checks++; if (key_code !== 16'd147) begin errors++; $display("FAIL f7_code got=%0d exp=147", key_code); end
    send(8'hF0); send(8'h83);
    send(8'h07);
    checks++; if (key_code !== 16'd152) begin errors++; $display("FAIL f12_code got=%0d exp=152", key_code); end
    l0 = n_load;
    send(8'h12);
    checks++; if (n_load - l0 !== 0) begin errors++; $display("FAIL unmapped_load got=%0d exp=0", n_load - l0); end
    checks++; if (key_code !== 16'd152) begin errors++; $display("FAIL unmapped_hold got=%0d exp=152", key_code); end
    send(8'hF0); send(8'h07);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL f12_release got=%0d exp=0", key_code); end
  endtask

  task automatic test_frame_err;
    int l0, f0;
    send(8'h45);
    l0 = n_load; f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL parity_ferr got=%0d exp=1", n_ferr - f0); end
    checks++; if (ferr_cyc - stop_cyc !== 7) begin errors++; $display("FAIL parity_latency got=%0d exp=7", ferr_cyc - stop_cyc); end
    checks++; if (n_load - l0 !== 0) begin errors++; $display("FAIL parity_load got=%0d exp=0", n_load - l0); end
    checks++; if (key_code !== 16'd48) begin errors++; $display("FAIL parity_hold got=%0d exp=48", key_code); end
    f0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_ferr got=%0d exp=1", n_ferr - f0); end
    checks++; if (n_load - l0 !== 0) begin errors++; $display("FAIL stop_load got=%0d exp=0", n_load - l0); end
    checks++; if (key_code !== 16'd48) begin errors++; $display("FAIL stop_hold got=%0d exp=48", key_code); end
    send(8'hE0);
    send_frame(8'h29, 1'b1, 1'b0, 11);
    send(8'h75);
    checks++; if (n_load - l0 !== 0) begin errors++; $display("FAIL err_clears_e0 got=%0d exp=0", n_load - l0); end
    send(8'hF0); send(8'h45);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL err_release got=%0d exp=0", key_code); end
  endtask

  task automatic test_timeout;
    int f0;
    f0 = n_ferr;
    send(8'hE0);
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    repeat (600) @(negedge clk);
    send(8'h29);
    checks++; if (key_code !== 16'd32) begin errors++; $display("FAIL timeout_code got=%0d exp=32", key_code); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL timeout_ferr got=%0d exp=0", n_ferr - f0); end
    send(8'hF0); send(8'h29);
  endtask

  task automatic test_back_to_back;
    int l0;
    send(8'h1C);
    send(8'h5A);
    checks++; if (key_code !== 16'd128) begin errors++; $display("FAIL hold_enter got=%0d exp=128", key_code); end
    l0 = n_load;
    send(8'hF0); send(8'h1C);
    checks++; if (n_load - l0 !== 0) begin errors++; $display("FAIL hold_stale_break got=%0d exp=0", n_load - l0); end
    checks++; if (key_code !== 16'd128) begin errors++; $display("FAIL hold_keep got=%0d exp=128", key_code); end
    send(8'hF0); send(8'h5A);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL hold_release got=%0d exp=0", key_code); end
    checks++; if (n_load - l0 !== 1) begin errors++; $display("FAIL hold_release_load got=%0d exp=1", n_load - l0); end
  endtask

  task automatic test_reset_midframe;
    int l0, f0;
    send(8'h1C);
    send_frame(8'h5A, 1'b0, 1'b0, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL midrst_key_code got=%0d exp=0", key_code); end
    repeat (3) @(negedge clk);
    checks++; if (key_load !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses got=%b%b exp=00", key_load, frame_err);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    l0 = n_load; f0 = n_ferr;
    send(8'h45);
    checks++; if (key_code !== 16'd48) begin errors++; $display("FAIL midrst_next got=%0d exp=48", key_code); end
    checks++; if (n_load - l0 !== 1 || n_ferr - f0 !== 0) begin
      errors++; $display("FAIL midrst_counts got=%0d/%0d exp=1/0", n_load - l0, n_ferr - f0);
    end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = n_ferr;
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
    send(8'hF0); send(8'h45);
    checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL glitch_code got=%0d exp=0", key_code); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - f0); end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL load_ferr_overlap got=%0d exp=0", n_both); end
  endtask

  initial begin
    test_reset;
    test_make;
    test_break;
    test_typematic;
    test_extended;
    test_fkeys_unmapped;
    test_frame_err;
    test_timeout;
    test_back_to_back;
    test_reset_midframe;
    test_glitch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
